// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   // Byte distance between consecutive instructions.
   localparam int PC_STEP = 4;

   // Widths of the standard core configuration.
   localparam int DEF_ADDR_W = 64;
   localparam int DEF_INS_W  = 32;

   // One fetched instruction together with the address it came from.
   // Modules built with non-default widths declare an identically laid out
   // local struct, since a package type cannot follow module parameters.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_INS_W-1:0]  ins;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush. Full/empty come from the occupancy
// counter; the pointers simply wrap. Push while full is accepted only when a
// pop happens in the same cycle. Flush wins over push and pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Next pointer/occupancy: flush empties the queue outright.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_W'(1);
         if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage; contents are meaningless once count says so, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: owns the PC, issues sequential fetches and queues
// {pc, instruction} pairs for decode. A redirect flushes the queue and
// restarts fetch at the (word-aligned) target.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 64,
   parameter int               INS_W    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int              CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic [ADDR_W-1:0] o_imAdd,
   output logic              o_imRd,
   input  logic              i_imRdy,
   input  logic [INS_W-1:0]  i_imIns,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirectPC,
   output logic              o_insValid,
   output logic [INS_W-1:0]  o_ins,
   output logic [ADDR_W-1:0] o_insPC,
   input  logic              i_insRdy,
   output logic [CNT_W-1:0]  o_count
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INS_W-1:0]  ins;
   } entry_t;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redir_pc;
   entry_t            push_ent, head_ent;
   logic              pop, fetch, q_empty, q_full;

   // Low two target bits are dropped: instructions are word aligned.
   assign redir_pc = i_redirectPC & ~ADDR_W'(3);

   assign pop      = o_insValid & i_insRdy;
   // A full queue may still accept a fetch when decode drains it this cycle.
   assign o_imRd   = i_rst_n & ~i_redirect & (~q_full | pop);
   assign fetch    = o_imRd & i_imRdy;
   assign o_imAdd  = pc_q;
   assign push_ent = '{pc: pc_q, ins: i_imIns};

   assign o_insValid = ~q_empty;
   assign o_ins      = head_ent.ins;
   assign o_insPC    = head_ent.pc;

   // Next PC: redirect beats sequential advance; a memory stall holds.
   always_comb begin
      pc_d = pc_q;
      if (i_redirect)  pc_d = redir_pc;
      else if (fetch)  pc_d = pc_q + ADDR_W'(PC_STEP);
   end

   // Program counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (fetch),
      .pop_i   (pop),
      .flush_i (i_redirect),
      .data_i  (push_ent),
      .data_o  (head_ent),
      .count_o (o_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: hand-derived vector table, wrap-around and
// async-reset sequences, then random traffic against a queue-based model.
module tb_instr_fetch_unit;

   localparam logic [31:0] INS_XOR = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] imAdd;
   logic        imRd, imRdy, redir, insValid, insRdy;
   logic [31:0] imIns, ins;
   logic [63:0] rpc, insPC;
   logic [2:0]  count;

   // Second instance: narrow address, two-entry queue, for wrap-around.
   logic [15:0] w_imAdd, w_rpc, w_insPC;
   logic        w_imRd, w_redir, w_valid;
   logic [31:0] w_imIns, w_ins;
   logic [1:0]  w_count;

   always #5 clk = ~clk;

   assign imIns   = imAdd[31:0] ^ INS_XOR;
   assign w_imIns = {16'h0, w_imAdd};

   instr_fetch_unit #(.ADDR_W(64), .INS_W(32), .DEPTH(4), .RESET_PC(64'h100)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .o_imAdd(imAdd), .o_imRd(imRd),
      .i_imRdy(imRdy), .i_imIns(imIns), .i_redirect(redir),
      .i_redirectPC(rpc), .o_insValid(insValid), .o_ins(ins),
      .o_insPC(insPC), .i_insRdy(insRdy), .o_count(count));

   instr_fetch_unit #(.ADDR_W(16), .INS_W(32), .DEPTH(2), .RESET_PC(16'h0)) dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .o_imAdd(w_imAdd), .o_imRd(w_imRd),
      .i_imRdy(1'b1), .i_imIns(w_imIns), .i_redirect(w_redir),
      .i_redirectPC(w_rpc), .o_insValid(w_valid), .o_ins(w_ins),
      .o_insPC(w_insPC), .i_insRdy(1'b1), .o_count(w_count));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: the queue as a list of {pc, ins}, the PC as a number.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } ment_t;
   ment_t       mq[$];
   logic [63:0] mpc;

   function automatic logic m_rd();
      return !redir && (mq.size() < 4 || (mq.size() != 0 && insRdy));
   endfunction

   task automatic model_check(input string tag);
      chk({tag, " valid"}, insValid, mq.size() != 0);
      chk({tag, " count"}, count, mq.size());
      chk({tag, " imRd"},  imRd, m_rd());
      chk({tag, " imAdd"}, imAdd, mpc);
      if (mq.size() != 0) begin
         chk({tag, " headPC"},  insPC, mq[0].pc);
         chk({tag, " headIns"}, ins, mq[0].ins);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge and let them settle.
   task automatic apply(input logic r, input logic [63:0] p, input logic mr, input logic dr);
      redir = r; rpc = p; imRdy = mr; insRdy = dr;
      #1;
   endtask

   // Clock the DUT once and advance the model by the same rules.
   task automatic advance();
      logic do_pop, do_fetch;
      @(posedge clk);
      do_pop   = (mq.size() != 0) && insRdy;
      do_fetch = m_rd() && imRdy;
      if (redir) begin
         mq.delete();
         mpc = {rpc[63:2], 2'b00};
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_fetch) begin
            mq.push_back('{pc: mpc, ins: mpc[31:0] ^ INS_XOR});
            mpc = mpc + 64'd4;
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        r;
      logic [63:0] p;
      logic        mr, dr;
      logic        ev;
      int          ec;
      logic        erd;
      logic [63:0] eadd, ehp;
   } vec_t;
   vec_t tv[21];

   initial begin
      // redir, target, imRdy, insRdy | valid, count, imRd, imAdd, headPC
      tv[0]  = '{0, 64'h0,    1, 1, 0, 0, 1, 64'h100,  64'h0};
      tv[1]  = '{0, 64'h0,    1, 1, 1, 1, 1, 64'h104,  64'h100};
      tv[2]  = '{0, 64'h0,    1, 1, 1, 1, 1, 64'h108,  64'h104};
      tv[3]  = '{0, 64'h0,    1, 1, 1, 1, 1, 64'h10C,  64'h108};
      tv[4]  = '{0, 64'h0,    1, 0, 1, 1, 1, 64'h110,  64'h10C};
      tv[5]  = '{0, 64'h0,    1, 0, 1, 2, 1, 64'h114,  64'h10C};
      tv[6]  = '{0, 64'h0,    1, 0, 1, 3, 1, 64'h118,  64'h10C};
      tv[7]  = '{0, 64'h0,    1, 0, 1, 4, 0, 64'h11C,  64'h10C};
      tv[8]  = '{0, 64'h0,    1, 0, 1, 4, 0, 64'h11C,  64'h10C};
      tv[9]  = '{0, 64'h0,    1, 0, 1, 4, 0, 64'h11C,  64'h10C};
      tv[10] = '{0, 64'h0,    1, 1, 1, 4, 1, 64'h11C,  64'h10C};
      tv[11] = '{0, 64'h0,    1, 1, 1, 4, 1, 64'h120,  64'h110};
      tv[12] = '{0, 64'h0,    1, 1, 1, 4, 1, 64'h124,  64'h114};
      tv[13] = '{0, 64'h0,    0, 1, 1, 4, 1, 64'h128,  64'h118};
      tv[14] = '{1, 64'h2003, 1, 1, 1, 3, 0, 64'h128,  64'h11C};
      tv[15] = '{0, 64'h0,    0, 1, 0, 0, 1, 64'h2000, 64'h0};
      tv[16] = '{0, 64'h0,    1, 1, 0, 0, 1, 64'h2000, 64'h0};
      tv[17] = '{0, 64'h0,    1, 1, 1, 1, 1, 64'h2004, 64'h2000};
      tv[18] = '{1, 64'h3000, 0, 0, 1, 1, 0, 64'h2008, 64'h2004};
      tv[19] = '{0, 64'h0,    1, 1, 0, 0, 1, 64'h3000, 64'h0};
      tv[20] = '{0, 64'h0,    1, 1, 1, 1, 1, 64'h3004, 64'h3000};

      rst_n = 1'b0; redir = 1'b0; rpc = '0; imRdy = 1'b1; insRdy = 1'b1;
      w_redir = 1'b0; w_rpc = '0;

      // Reset state: no request even though memory and decode are ready.
      @(negedge clk); #1;
      chk("rst valid", insValid, 0);
      chk("rst count", count, 0);
      chk("rst imRd",  imRd, 0);
      chk("rst imAdd", imAdd, 64'h100);

      @(negedge clk);
      rst_n = 1'b1;
      mq.delete(); mpc = 64'h100;

      // Sequential fetch, backpressure, full+pop, redirects.
      for (int i = 0; i < 21; i++) begin
         apply(tv[i].r, tv[i].p, tv[i].mr, tv[i].dr);
         chk($sformatf("vec%0d valid", i), insValid, tv[i].ev);
         chk($sformatf("vec%0d count", i), count, tv[i].ec);
         chk($sformatf("vec%0d imRd", i),  imRd, tv[i].erd);
         chk($sformatf("vec%0d imAdd", i), imAdd, tv[i].eadd);
         if (tv[i].ev) begin
            chk($sformatf("vec%0d headPC", i), insPC, tv[i].ehp);
            chk($sformatf("vec%0d headIns", i), ins, tv[i].ehp[31:0] ^ INS_XOR);
         end
         advance();
      end

      // Narrow instance: redirect near the top of the address space wraps.
      w_redir = 1'b1; w_rpc = 16'hFFFE;
      apply(0, 64'h0, 1, 1); model_check("pre-wrap"); advance();
      w_redir = 1'b0;
      chk("wrap imAdd0", w_imAdd, 16'hFFFC);
      chk("wrap valid0", w_valid, 0);
      apply(0, 64'h0, 1, 1); model_check("wrap1"); advance();
      chk("wrap imAdd1", w_imAdd, 16'h0000);
      chk("wrap headPC1", w_insPC, 16'hFFFC);
      chk("wrap headIns1", w_ins, 32'h0000_FFFC);
      apply(0, 64'h0, 1, 1); model_check("wrap2"); advance();
      chk("wrap headPC2", w_insPC, 16'h0000);
      chk("wrap imAdd2", w_imAdd, 16'h0004);

      // Random traffic, including stalls and redirects anywhere.
      for (int c = 0; c < 600; c++) begin
         apply($urandom_range(15) == 0, {$urandom, $urandom},
               $urandom_range(9) < 7, $urandom_range(9) < 6);
         model_check("rand");
         advance();
      end

      // Build three queued entries, then reset between clock edges.
      apply(1, 64'h500, 1, 0); model_check("pre-rst"); advance();
      for (int k = 0; k < 3; k++) begin
         apply(0, 64'h0, 1, 0); model_check("fill"); advance();
      end
      chk("fill count", count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst valid", insValid, 0);
      chk("arst count", count, 0);
      chk("arst imRd",  imRd, 0);
      chk("arst imAdd", imAdd, 64'h100);
      chk("arst wcount", w_count, 0);
      mq.delete(); mpc = 64'h100;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         apply(0, 64'h0, 1, 1); model_check("post-rst"); advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
